// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-consumer bundle around the UART receive FIFO: byte strobe in, FWFT byte and status out.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) ();
  logic                       i_rx_valid;
  logic [WIDTH-1:0]           i_rx_byte;
  logic                       i_rd_en;
  logic                       i_clr_ovf;
  logic [WIDTH-1:0]           o_rd_data;
  logic                       o_empty;
  logic                       o_full;
  logic [$clog2(DEPTH):0]     o_count;
  logic                       o_overflow;

  modport master (
    output i_rx_valid, i_rx_byte, i_rd_en, i_clr_ovf,
    input  o_rd_data, o_empty, o_full, o_count, o_overflow
  );

  modport slave (
    input  i_rx_valid, i_rx_byte, i_rd_en, i_clr_ovf,
    output o_rd_data, o_empty, o_full, o_count, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular FWFT byte buffer behind the UART receiver; a stored byte is readable 1 cycle after its strobe.
// No backpressure to the receiver: a strobe while full without a pop is dropped and sets sticky overflow.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic          source_clk,
  input  logic          i_rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             push_ok;
  logic             pop_ok;
  logic             drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign pop_ok  = bus.i_rd_en & ~empty;
  assign push_ok = bus.i_rx_valid & (~full | pop_ok);
  assign drop    = bus.i_rx_valid & full & ~pop_ok;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge source_clk) begin
    if (!i_rst && push_ok) begin
      mem[wr_ptr] <= bus.i_rx_byte;
    end
  end

  always_ff @(posedge source_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      if (drop) begin
        overflow <= 1'b1;
      end else if (bus.i_clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.o_rd_data  = empty ? '0 : mem[rd_ptr];
  assign bus.o_empty    = empty;
  assign bus.o_full     = full;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with DEPTH=16, WIDTH=8.
module tb_uart_rx_fifo;
  logic source_clk = 1'b0;
  logic i_rst      = 1'b1;
  int   n_checks   = 0;
  int   n_fail     = 0;

  uart_rx_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

  uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .source_clk (source_clk),
    .i_rst      (i_rst),
    .bus        (bus)
  );

  always #5 source_clk = ~source_clk;

  task automatic step();
    @(posedge source_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = b;
    step();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
  endtask

  task automatic pop();
    bus.i_rd_en = 1'b1;
    step();
    bus.i_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    step();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.o_empty); end
    n_checks++; if (bus.o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.o_full); end
    n_checks++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", bus.o_overflow); end
    n_checks++; if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", bus.o_rd_data); end
    pop();
    n_checks++;
    if (bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_count !== 5'd0 ||
        bus.o_overflow !== 1'b0 || bus.o_rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL pop_on_empty got e=%b f=%b c=%0d o=%b d=%h want e=1 f=0 c=0 o=0 d=00",
               bus.o_empty, bus.o_full, bus.o_count, bus.o_overflow, bus.o_rd_data);
    end
  endtask

  task automatic test_single_byte();
    push(8'h41);
    n_checks++; if (bus.o_rd_data !== 8'h41) begin n_fail++; $display("FAIL single_data got %h want 41", bus.o_rd_data); end
    n_checks++; if (bus.o_count !== 5'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.o_count); end
    n_checks++; if (bus.o_empty !== 1'b0) begin n_fail++; $display("FAIL single_not_empty got %b want 0", bus.o_empty); end
    pop();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL single_drained_empty got %b want 1", bus.o_empty); end
    n_checks++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL single_drained_count got %0d want 0", bus.o_count); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 16; i++) push(8'(i));
    n_checks++; if (bus.o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", bus.o_full); end
    n_checks++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", bus.o_count); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.o_rd_data !== 8'(i)) begin n_fail++; $display("FAIL fill_head%0d got %h want %h", i, bus.o_rd_data, 8'(i)); end
      pop();
    end
    n_checks++; if (bus.o_count !== 5'd12 || bus.o_full !== 1'b0) begin n_fail++; $display("FAIL after_pop4 got c=%0d f=%b want c=12 f=0", bus.o_count, bus.o_full); end
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    n_checks++; if (bus.o_full !== 1'b1 || bus.o_count !== 5'd16) begin n_fail++; $display("FAIL wrap_full got c=%0d f=%b want c=16 f=1", bus.o_count, bus.o_full); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.o_rd_data !== 8'h04 + 8'(i)) begin n_fail++; $display("FAIL wrap_drain%0d got %h want %h", i, bus.o_rd_data, 8'h04 + 8'(i)); end
      pop();
    end
    n_checks++; if (bus.o_empty !== 1'b1 || bus.o_count !== 5'd0) begin n_fail++; $display("FAIL wrap_end got e=%b c=%0d want e=1 c=0", bus.o_empty, bus.o_count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    push(8'hEE);
    n_checks++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", bus.o_overflow); end
    n_checks++; if (bus.o_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", bus.o_count); end
    // clear and a new drop in one cycle: set must win
    bus.i_clr_ovf = 1'b1;
    push(8'hEE);
    bus.i_clr_ovf = 1'b0;
    n_checks++; if (bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", bus.o_overflow); end
    bus.i_clr_ovf = 1'b1;
    step();
    bus.i_clr_ovf = 1'b0;
    n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", bus.o_overflow); end
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (bus.o_rd_data !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain%0d got %h want %h", i, bus.o_rd_data, 8'hA0 + 8'(i)); end
      pop();
    end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_end_empty got %b want 1", bus.o_empty); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) push(8'hB0 + 8'(i));
    bus.i_rd_en = 1'b1;
    push(8'h55);
    bus.i_rd_en = 1'b0;
    n_checks++; if (bus.o_count !== 5'd16 || bus.o_full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop_count got c=%0d f=%b want c=16 f=1", bus.o_count, bus.o_full); end
    n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf got %b want 0", bus.o_overflow); end
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (bus.o_rd_data !== 8'hB1 + 8'(i)) begin n_fail++; $display("FAIL full_pushpop_drain%0d got %h want %h", i, bus.o_rd_data, 8'hB1 + 8'(i)); end
      pop();
    end
    n_checks++; if (bus.o_rd_data !== 8'h55 || bus.o_count !== 5'd1) begin n_fail++; $display("FAIL full_pushpop_last got d=%h c=%0d want d=55 c=1", bus.o_rd_data, bus.o_count); end
    pop();
    bus.i_rd_en = 1'b1;
    push(8'h66);
    bus.i_rd_en = 1'b0;
    n_checks++; if (bus.o_count !== 5'd1) begin n_fail++; $display("FAIL empty_pushpop_count got %0d want 1", bus.o_count); end
    n_checks++; if (bus.o_rd_data !== 8'h66) begin n_fail++; $display("FAIL empty_pushpop_data got %h want 66", bus.o_rd_data); end
    pop();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL empty_pushpop_end got %b want 1", bus.o_empty); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    push(8'hEE);
    for (int i = 0; i < 11; i++) pop();
    n_checks++; if (bus.o_count !== 5'd5 || bus.o_overflow !== 1'b1) begin n_fail++; $display("FAIL pre_reset got c=%0d o=%b want c=5 o=1", bus.o_count, bus.o_overflow); end
    i_rst = 1'b1;
    push(8'h77);
    i_rst = 1'b0;
    n_checks++; if (bus.o_count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", bus.o_count); end
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b want 1", bus.o_empty); end
    n_checks++; if (bus.o_overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got %b want 0", bus.o_overflow); end
    n_checks++; if (bus.o_rd_data !== 8'h00) begin n_fail++; $display("FAIL midrst_rd_data got %h want 00", bus.o_rd_data); end
    push(8'h88);
    n_checks++; if (bus.o_rd_data !== 8'h88 || bus.o_count !== 5'd1) begin n_fail++; $display("FAIL midrst_next got d=%h c=%0d want d=88 c=1", bus.o_rd_data, bus.o_count); end
    pop();
    n_checks++; if (bus.o_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_end got %b want 1", bus.o_empty); end
  endtask

  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
    bus.i_rd_en    = 1'b0;
    bus.i_clr_ovf  = 1'b0;
    test_reset();
    test_single_byte();
    test_fill_wrap();
    test_overflow();
    test_simultaneous();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
